// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and requester ids for the RegFile write-port arbiter.
// The round-robin pick helper is shared so the grant rule lives in exactly one place.
package regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_REGS = 32;
  localparam logic [RF_DATA_W-1:0] RF_INIT_VAL = 32'h0000_0000;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic REQ_WB = 1'b0;
  localparam logic REQ_MC = 1'b1;

  // One-hot grant for two requesters; ptr selects the winner only on contention.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic ptr);
    logic [1:0] pick;
    case (valid)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = ptr ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the two write-request handshakes, the hold input and the RegFile write port.
// slave is the arbiter side, master is the pipeline/RegFile side.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              hold;
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              rg_wrt_en;
  logic [ADDR_W-1:0] rg_wrt_addr;
  logic [DATA_W-1:0] rg_wrt_data;
  logic              init_done;
  logic              last_grant;

  modport slave (
    input  hold,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output rg_wrt_en, rg_wrt_addr, rg_wrt_data,
    output init_done, last_grant
  );

  modport master (
    output hold,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  rg_wrt_en, rg_wrt_addr, rg_wrt_data,
    input  init_done, last_grant
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational one-hot grant, pointer register
// that moves to the loser after every grant.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hold,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic       ptr_r;
  logic [1:0] grant_s;

  // Grant selection; nothing is granted while disabled or held.
  always_comb begin
    grant_s = 2'b00;
    if (en && !hold) begin
      grant_s = rr_pick(valid, ptr_r);
    end else begin
      grant_s = 2'b00;
    end
  end

  // Pointer register: favour the requester that did not win this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= 1'b0;
    end else if (grant_s[0]) begin
      ptr_r <= 1'b1;
    end else if (grant_s[1]) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Sole owner of the RegFile write port: clears every register after reset,
// then arbitrates writeback and multicycle/loader writes round-robin.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter logic [DATA_W-1:0] INIT_VAL = RF_INIT_VAL
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wr_arbiter_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  state_e            state_r, state_nxt_s;
  logic [ADDR_W-1:0] init_cnt_r, init_cnt_nxt_s;
  logic              wr_en_r, wr_en_nxt_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_nxt_s;
  logic [DATA_W-1:0] wr_data_r, wr_data_nxt_s;
  logic              init_done_r;
  logic              last_grant_r, last_grant_nxt_s;
  logic [1:0]        grant_s;
  logic              arb_en_s;

  assign arb_en_s = (state_r == ST_RUN);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en_s),
    .hold  (bus.hold),
    .valid ({bus.req1_valid, bus.req0_valid}),
    .grant (grant_s)
  );

  // Next-state and next-output logic for the clear sequence and arbitration.
  always_comb begin
    state_nxt_s      = state_r;
    init_cnt_nxt_s   = init_cnt_r;
    wr_en_nxt_s      = 1'b0;
    wr_addr_nxt_s    = wr_addr_r;
    wr_data_nxt_s    = wr_data_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      ST_INIT: begin
        wr_en_nxt_s    = 1'b1;
        wr_addr_nxt_s  = init_cnt_r;
        wr_data_nxt_s  = INIT_VAL;
        init_cnt_nxt_s = init_cnt_r + ONE_ADDR;
        if (init_cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        // Writes to $0 are accepted but never reach the RegFile.
        if (grant_s[0]) begin
          last_grant_nxt_s = REQ_WB;
          if (bus.req0_addr != ZERO_ADDR) begin
            wr_en_nxt_s   = 1'b1;
            wr_addr_nxt_s = bus.req0_addr;
            wr_data_nxt_s = bus.req0_data;
          end else begin
            wr_en_nxt_s = 1'b0;
          end
        end else if (grant_s[1]) begin
          last_grant_nxt_s = REQ_MC;
          if (bus.req1_addr != ZERO_ADDR) begin
            wr_en_nxt_s   = 1'b1;
            wr_addr_nxt_s = bus.req1_addr;
            wr_data_nxt_s = bus.req1_data;
          end else begin
            wr_en_nxt_s = 1'b0;
          end
        end else begin
          wr_en_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s    = ST_INIT;
        init_cnt_nxt_s = ZERO_ADDR;
      end
    endcase
  end

  // State, init counter and registered RegFile write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_INIT;
      init_cnt_r   <= ZERO_ADDR;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= ZERO_ADDR;
      wr_data_r    <= {DATA_W{1'b0}};
      init_done_r  <= 1'b0;
      last_grant_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      init_cnt_r   <= init_cnt_nxt_s;
      wr_en_r      <= wr_en_nxt_s;
      wr_addr_r    <= wr_addr_nxt_s;
      wr_data_r    <= wr_data_nxt_s;
      init_done_r  <= (state_nxt_s == ST_RUN);
      last_grant_r <= last_grant_nxt_s;
    end
  end

  assign bus.req0_ready  = grant_s[0];
  assign bus.req1_ready  = grant_s[1];
  assign bus.rg_wrt_en   = wr_en_r;
  assign bus.rg_wrt_addr = wr_addr_r;
  assign bus.rg_wrt_data = wr_data_r;
  assign bus.init_done   = init_done_r;
  assign bus.last_grant  = last_grant_r;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: clear sequence, single writes, contention,
// $0 suppression, hold and mid-run reset, with hand-computed expectations.
module tb_regfile_wr_arbiter;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   err_cnt;

  regfile_wr_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.hold       = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_addr  = 5'd0;
    bus.req0_data  = 32'd0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = 5'd0;
    bus.req1_data  = 32'd0;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst = 1'b0;
    #13;
    chk_cnt++;
    if ({bus.rg_wrt_en, bus.rg_wrt_addr, bus.rg_wrt_data} !== 38'd0) begin
      err_cnt++;
      $display("FAIL reset_wr_port: got en=%0b addr=%0h data=%0h, want all 0",
               bus.rg_wrt_en, bus.rg_wrt_addr, bus.rg_wrt_data);
    end
    chk_cnt++;
    if ({bus.init_done, bus.last_grant, bus.req0_ready, bus.req1_ready} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_status: got done=%0b lg=%0b r0=%0b r1=%0b, want 0000",
               bus.init_done, bus.last_grant, bus.req0_ready, bus.req1_ready);
    end
  endtask

  // Walks the 32-cycle clear; valid is asserted early to prove INIT ignores it.
  task automatic run_init(input string tag, input logic keep_req0);
    logic [4:0] exp_a;
    logic       exp_done;
    for (int k = 1; k <= 32; k++) begin
      chk_cnt++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL %s_ready_in_init: cycle %0d got r0=%0b r1=%0b, want 0 0",
                 tag, k, bus.req0_ready, bus.req1_ready);
      end
      step();
      exp_a    = 5'(k - 1);
      exp_done = (k == 32);
      chk_cnt++;
      if (bus.rg_wrt_en !== 1'b1 || bus.rg_wrt_addr !== exp_a || bus.rg_wrt_data !== 32'h0) begin
        err_cnt++;
        $display("FAIL %s_clear_write: edge %0d got en=%0b addr=%0h data=%0h, want en=1 addr=%0h data=0",
                 tag, k, bus.rg_wrt_en, bus.rg_wrt_addr, bus.rg_wrt_data, exp_a);
      end
      chk_cnt++;
      if (bus.init_done !== exp_done) begin
        err_cnt++;
        $display("FAIL %s_init_done: edge %0d got %0b, want %0b", tag, k, bus.init_done, exp_done);
      end
      if (k == 31 && !keep_req0) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
  endtask

  task automatic test_init();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd3;
    bus.req0_data  = 32'h33;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'd4;
    bus.req1_data  = 32'h44;
    step();
    #2 rst = 1'b1;
    #1;
    run_init("init", 1'b0);
    step();
    chk_cnt++;
    if (bus.rg_wrt_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL init_idle_after: got en=%0b, want 0", bus.rg_wrt_en);
    end
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'h18;
    bus.req0_data  = 32'h0000_0045;
    #1;
    chk_cnt++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_ready: got r0=%0b r1=%0b, want 1 0", bus.req0_ready, bus.req1_ready);
    end
    step();
    bus.req0_valid = 1'b0;
    chk_cnt++;
    if (bus.rg_wrt_en !== 1'b1 || bus.rg_wrt_addr !== 5'h18 || bus.rg_wrt_data !== 32'h45 ||
        bus.last_grant !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_write: got en=%0b addr=%0h data=%0h lg=%0b, want 1 18 45 0",
               bus.rg_wrt_en, bus.rg_wrt_addr, bus.rg_wrt_data, bus.last_grant);
    end
    step();
    chk_cnt++;
    if (bus.rg_wrt_en !== 1'b0 || bus.rg_wrt_addr !== 5'h18 || bus.rg_wrt_data !== 32'h45) begin
      err_cnt++;
      $display("FAIL idle_hold_port: got en=%0b addr=%0h data=%0h, want 0 18 45",
               bus.rg_wrt_en, bus.rg_wrt_addr, bus.rg_wrt_data);
    end
  endtask

  // Pointer sits at 1 after the req0 grant, so req1 alone is granted anyway.
  task automatic test_zero_reg();
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'h00;
    bus.req1_data  = 32'hFFFF_FFFF;
    #1;
    chk_cnt++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL zero_ready: got r0=%0b r1=%0b, want 0 1", bus.req0_ready, bus.req1_ready);
    end
    step();
    bus.req1_valid = 1'b0;
    chk_cnt++;
    if (bus.rg_wrt_en !== 1'b0 || bus.last_grant !== 1'b1) begin
      err_cnt++;
      $display("FAIL zero_suppress: got en=%0b lg=%0b, want en=0 lg=1", bus.rg_wrt_en, bus.last_grant);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy [4];
    logic [4:0] exp_a   [4];
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
    exp_a[0] = 5'h05; exp_a[1] = 5'h06; exp_a[2] = 5'h05; exp_a[3] = 5'h06;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'h05; bus.req0_data = 32'hA;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'h06; bus.req1_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_cnt++;
      if ({bus.req1_ready, bus.req0_ready} !== exp_rdy[i]) begin
        err_cnt++;
        $display("FAIL b2b_ready[%0d]: got r1r0=%b, want %b", i, {bus.req1_ready, bus.req0_ready}, exp_rdy[i]);
      end
      step();
      chk_cnt++;
      if (bus.rg_wrt_en !== 1'b1 || bus.rg_wrt_addr !== exp_a[i] || bus.last_grant !== exp_rdy[i][1]) begin
        err_cnt++;
        $display("FAIL b2b_write[%0d]: got en=%0b addr=%0h lg=%0b, want 1 %0h %0b",
                 i, bus.rg_wrt_en, bus.rg_wrt_addr, bus.last_grant, exp_a[i], exp_rdy[i][1]);
      end
    end
  endtask

  task automatic test_hold();
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL hold_ready[%0d]: got r0=%0b r1=%0b, want 0 0", i, bus.req0_ready, bus.req1_ready);
      end
      step();
      chk_cnt++;
      if (bus.rg_wrt_en !== 1'b0) begin
        err_cnt++;
        $display("FAIL hold_wr_en[%0d]: got %0b, want 0", i, bus.rg_wrt_en);
      end
    end
    bus.hold = 1'b0;
    #1;
    chk_cnt++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL hold_release: got r0=%0b r1=%0b, want 1 0", bus.req0_ready, bus.req1_ready);
    end
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk_cnt++;
    if (bus.rg_wrt_en !== 1'b1 || bus.rg_wrt_addr !== 5'h05 || bus.rg_wrt_data !== 32'hA) begin
      err_cnt++;
      $display("FAIL hold_release_write: got en=%0b addr=%0h data=%0h, want 1 05 a",
               bus.rg_wrt_en, bus.rg_wrt_addr, bus.rg_wrt_data);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.req1_valid = 1'b1; bus.req1_addr = 5'h07; bus.req1_data = 32'h77;
    step();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'h09; bus.req0_data = 32'h99;
    #2 rst = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.rg_wrt_en, bus.rg_wrt_addr, bus.rg_wrt_data, bus.init_done, bus.last_grant, bus.req0_ready}
        !== 41'd0) begin
      err_cnt++;
      $display("FAIL midrst_zero: got en=%0b addr=%0h data=%0h done=%0b lg=%0b r0=%0b, want all 0",
               bus.rg_wrt_en, bus.rg_wrt_addr, bus.rg_wrt_data, bus.init_done, bus.last_grant, bus.req0_ready);
    end
    #2 rst = 1'b1;
    run_init("midrst", 1'b1);
    chk_cnt++;
    if (bus.req0_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_first_grant: got r0=%0b, want 1", bus.req0_ready);
    end
    step();
    bus.req0_valid = 1'b0;
    chk_cnt++;
    if (bus.rg_wrt_en !== 1'b1 || bus.rg_wrt_addr !== 5'h09 || bus.rg_wrt_data !== 32'h99 ||
        bus.last_grant !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrst_write: got en=%0b addr=%0h data=%0h lg=%0b, want 1 09 99 0",
               bus.rg_wrt_en, bus.rg_wrt_addr, bus.rg_wrt_data, bus.last_grant);
    end
  endtask

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_init();
    test_single();
    test_zero_reg();
    test_back_to_back();
    test_hold();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
